// File: rtl/music_pkg.sv
// Shared definitions for the music sequencer command path: command layout,
// end-of-score marker and the score_player state encoding.
package music_pkg;

    localparam int CMD_W    = 12;
    localparam int NOTE_W   = 4;
    localparam int OCTAVE_W = 3;
    localparam int DUR_W    = 5;

    localparam logic [CMD_W-1:0] END_WORD = 12'h000;

    typedef struct packed {
        logic [DUR_W-1:0]    dur;
        logic [OCTAVE_W-1:0] octave;
        logic [NOTE_W-1:0]   note;
    } note_cmd_t;

    typedef enum logic [2:0] {
        SP_IDLE  = 3'd0,
        SP_FETCH = 3'd1,
        SP_LOAD  = 3'd2,
        SP_ISSUE = 3'd3,
        SP_PLAY  = 3'd4,
        SP_GAP   = 3'd5
    } sp_state_e;

    // Bits needed to hold max_val-1, never less than one.
    function automatic int tmr_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/score_player_timer.sv
// Loadable down-counter shared by the ack timeout and the articulation gap;
// tc is high while the count sits at zero.
module score_player_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign tc = (r_count == '0);

endmodule

// File: rtl/score_rom.sv
// Synchronous score ROM, one clock read latency. Contents come from the INIT
// image, word 0 in the least significant CMD_W bits.
module score_rom
    import music_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter logic [(2**ADDR_W)*CMD_W-1:0] INIT = '0
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [CMD_W-1:0]  data
);

    always_ff @(posedge clk) begin
        data <= INIT[addr*CMD_W +: CMD_W];
    end

endmodule

// File: rtl/score_player.sv
// Walks the score ROM and issues one note command at a time to the sequencer.
//   state | meaning
//   IDLE  | command bus at END_WORD, waiting for start
//   FETCH | ROM address presented, waiting out read latency
//   LOAD  | ROM word valid: end-of-score check or latch command
//   ISSUE | command driven, waiting for busy (bounded by ACK_TIMEOUT)
//   PLAY  | note accepted, waiting for busy to fall
//   GAP   | articulation gap before next fetch
module score_player #(
    parameter int ADDR_W      = 8,
    parameter int GAP_CYCLES  = 512,
    parameter int ACK_TIMEOUT = 16,
    parameter logic [music_pkg::CMD_W-1:0] END_WORD = music_pkg::END_WORD
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        loop_en,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [music_pkg::CMD_W-1:0] rom_data,
    output logic [music_pkg::CMD_W-1:0] command,
    input  logic                        busy,
    output logic                        playing,
    output logic                        done,
    output logic                        err
);
    import music_pkg::*;

    localparam int TMR_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
    localparam int TMR_W   = tmr_width(TMR_MAX);
    localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sp_state_e          r_state, w_state_nxt;
    logic [CMD_W-1:0]   r_cmd, w_cmd_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic               r_wrap, w_wrap_nxt;
    logic               r_done, w_done_nxt;
    logic               r_err, w_err_nxt;
    logic               w_tmr_load, w_tmr_dec, w_tmr_tc;
    logic [TMR_W-1:0]   w_tmr_val;

    score_player_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tmr_load),
        .dec      (w_tmr_dec),
        .load_val (w_tmr_val),
        .tc       (w_tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SP_IDLE;
            r_cmd   <= END_WORD;
            r_addr  <= '0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cmd   <= w_cmd_nxt;
            r_addr  <= w_addr_nxt;
            r_wrap  <= w_wrap_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_addr_nxt  = r_addr;
        w_wrap_nxt  = r_wrap;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        w_tmr_load  = 1'b0;
        w_tmr_dec   = 1'b0;
        w_tmr_val   = ACK_LOAD;
        if (stop) begin
            w_state_nxt = SP_IDLE;
            w_cmd_nxt   = END_WORD;
        end else begin
            unique case (r_state)
                SP_IDLE: begin
                    if (start) begin
                        w_addr_nxt  = '0;
                        w_wrap_nxt  = 1'b0;
                        w_err_nxt   = 1'b0;
                        w_state_nxt = SP_FETCH;
                    end
                end
                SP_FETCH: w_state_nxt = SP_LOAD;
                SP_LOAD: begin
                    // A wrapped address ends the score whatever the ROM returns.
                    if (r_wrap || (rom_data == END_WORD)) begin
                        if (loop_en) begin
                            w_addr_nxt  = '0;
                            w_wrap_nxt  = 1'b0;
                            w_state_nxt = SP_FETCH;
                        end else begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = SP_IDLE;
                        end
                    end else begin
                        w_cmd_nxt   = rom_data;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = ACK_LOAD;
                        w_state_nxt = SP_ISSUE;
                    end
                end
                SP_ISSUE: begin
                    if (busy) begin
                        w_cmd_nxt   = END_WORD;
                        w_addr_nxt  = r_addr + 1'b1;
                        if (&r_addr) w_wrap_nxt = 1'b1;
                        w_state_nxt = SP_PLAY;
                    end else if (w_tmr_tc) begin
                        w_err_nxt   = 1'b1;
                        w_cmd_nxt   = END_WORD;
                        w_state_nxt = SP_IDLE;
                    end else begin
                        w_tmr_dec = 1'b1;
                    end
                end
                SP_PLAY: begin
                    if (!busy) begin
                        if (GAP_CYCLES == 0) begin
                            w_state_nxt = SP_FETCH;
                        end else begin
                            w_tmr_load  = 1'b1;
                            w_tmr_val   = GAP_LOAD;
                            w_state_nxt = SP_GAP;
                        end
                    end
                end
                SP_GAP: begin
                    if (w_tmr_tc) w_state_nxt = SP_FETCH;
                    else          w_tmr_dec   = 1'b1;
                end
                default: begin
                    w_cmd_nxt   = END_WORD;
                    w_state_nxt = SP_IDLE;
                end
            endcase
        end
    end

    assign rom_addr = r_addr;
    assign command  = r_cmd;
    assign playing  = (r_state != SP_IDLE);
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_score_player.sv
// Directed bench for score_player: three instances (default gap, 2-bit address
// wrap, zero gap) each fed by a score ROM and a simple sequencer model.
module tb_score_player;

    logic        clk;
    logic        rst_n;
    logic [2:0]  start;
    logic [2:0]  stop;
    logic [2:0]  loop_en;
    logic [2:0]  busy;
    logic [2:0]  seq_mode;

    wire  [7:0]  addr_a;
    wire  [1:0]  addr_b;
    wire  [7:0]  addr_c;
    wire  [11:0] rdat_w [3];
    wire  [11:0] cmd_w  [3];
    wire  [2:0]  pl_w;
    wire  [2:0]  done_w;
    wire  [2:0]  err_w;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] mon_notes[$];
    int          mon_ks[$];
    int          mon_dones;
    int          mon_done_k;
    int          mon_glitch;

    int sq_dly  [3];
    int sq_hold [3];

    localparam logic [256*12-1:0] ROM_A = {{253{12'h000}}, 12'h000, 12'h840, 12'h43f};
    localparam logic [4*12-1:0]   ROM_B = {12'h823, 12'h822, 12'h821, 12'h820};

    score_rom #(.ADDR_W(8), .INIT(ROM_A)) u_rom_a (.clk(clk), .addr(addr_a), .data(rdat_w[0]));
    score_rom #(.ADDR_W(2), .INIT(ROM_B)) u_rom_b (.clk(clk), .addr(addr_b), .data(rdat_w[1]));
    score_rom #(.ADDR_W(8), .INIT(ROM_A)) u_rom_c (.clk(clk), .addr(addr_c), .data(rdat_w[2]));

    score_player #(.ADDR_W(8), .GAP_CYCLES(4), .ACK_TIMEOUT(16), .END_WORD(12'h000)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .stop(stop[0]), .loop_en(loop_en[0]),
        .rom_addr(addr_a), .rom_data(rdat_w[0]), .command(cmd_w[0]), .busy(busy[0]),
        .playing(pl_w[0]), .done(done_w[0]), .err(err_w[0])
    );

    score_player #(.ADDR_W(2), .GAP_CYCLES(4), .ACK_TIMEOUT(16), .END_WORD(12'h000)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .stop(stop[1]), .loop_en(loop_en[1]),
        .rom_addr(addr_b), .rom_data(rdat_w[1]), .command(cmd_w[1]), .busy(busy[1]),
        .playing(pl_w[1]), .done(done_w[1]), .err(err_w[1])
    );

    score_player #(.ADDR_W(8), .GAP_CYCLES(0), .ACK_TIMEOUT(16), .END_WORD(12'h000)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .stop(stop[2]), .loop_en(loop_en[2]),
        .rom_addr(addr_c), .rom_data(rdat_w[2]), .command(cmd_w[2]), .busy(busy[2]),
        .playing(pl_w[2]), .done(done_w[2]), .err(err_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sequencer model: busy rises 2 clocks after a note appears, stays 20 clocks.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n || !seq_mode[i]) begin
                busy[i] = 1'b0; sq_dly[i] = 0; sq_hold[i] = 0;
            end else if (busy[i]) begin
                sq_hold[i] = sq_hold[i] - 1;
                if (sq_hold[i] == 0) busy[i] = 1'b0;
            end else if (cmd_w[i] != 12'h000) begin
                sq_dly[i] = sq_dly[i] + 1;
                if (sq_dly[i] == 2) begin
                    busy[i] = 1'b1; sq_hold[i] = 20; sq_dly[i] = 0;
                end
            end else begin
                sq_dly[i] = 0;
            end
        end
    end

    function automatic logic [11:0] note_at(input int i);
        return (mon_notes.size() > i) ? mon_notes[i] : 12'hfff;
    endfunction

    function automatic int k_at(input int i);
        return (mon_ks.size() > i) ? mon_ks[i] : -1;
    endfunction

    // Caller raises start[d] just before; k counts clocks since that edge.
    task automatic run_collect(input int d, input int ncyc, input int xk);
        logic [11:0] prev, cur;
        mon_notes.delete(); mon_ks.delete();
        mon_dones = 0; mon_done_k = 0; mon_glitch = 0;
        prev = cmd_w[d];
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (k == 1) start[d] = 1'b0;
            if (xk != 0 && k == xk) start[d] = 1'b1;
            if (xk != 0 && k == xk + 1) start[d] = 1'b0;
            cur = cmd_w[d];
            if (cur !== prev && cur !== 12'h000) begin
                mon_notes.push_back(cur); mon_ks.push_back(k);
            end
            if (prev !== 12'h000 && cur !== 12'h000 && cur !== prev) mon_glitch++;
            if (done_w[d] === 1'b1) begin mon_dones++; mon_done_k = k; end
            prev = cur;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (cmd_w[0] !== 12'h000) begin n_errors++; $display("FAIL reset_command: got %0h expected 0", cmd_w[0]); end
        n_checks++; if (pl_w[0] !== 1'b0) begin n_errors++; $display("FAIL reset_playing: got %0b expected 0", pl_w[0]); end
        n_checks++; if (done_w[0] !== 1'b0 || err_w[0] !== 1'b0) begin n_errors++; $display("FAIL reset_done_err: got %0b/%0b expected 0/0", done_w[0], err_w[0]); end
        n_checks++; if (addr_a !== 8'd0) begin n_errors++; $display("FAIL reset_rom_addr: got %0d expected 0", addr_a); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_play_once();
        loop_en[0] = 1'b0;
        start[0] = 1'b1;
        run_collect(0, 80, 0);
        n_checks++; if (note_at(0) !== 12'h43f) begin n_errors++; $display("FAIL once_note0: got %0h expected 43f", note_at(0)); end
        n_checks++; if (k_at(0) != 3) begin n_errors++; $display("FAIL once_start_latency: got %0d expected 3", k_at(0)); end
        n_checks++; if (note_at(1) !== 12'h840) begin n_errors++; $display("FAIL once_note1: got %0h expected 840", note_at(1)); end
        n_checks++; if (k_at(1) != 31) begin n_errors++; $display("FAIL once_gap_latency: got %0d expected 31", k_at(1)); end
        n_checks++; if (mon_notes.size() != 2) begin n_errors++; $display("FAIL once_note_count: got %0d expected 2", mon_notes.size()); end
        n_checks++; if (mon_dones != 1) begin n_errors++; $display("FAIL once_done_count: got %0d expected 1", mon_dones); end
        n_checks++; if (mon_done_k != 59) begin n_errors++; $display("FAIL once_done_time: got %0d expected 59", mon_done_k); end
        n_checks++; if (addr_a !== 8'd2) begin n_errors++; $display("FAIL once_rom_addr: got %0d expected 2", addr_a); end
        n_checks++; if (mon_glitch != 0) begin n_errors++; $display("FAIL once_note_to_note: got %0d expected 0", mon_glitch); end
        n_checks++; if (pl_w[0] !== 1'b0) begin n_errors++; $display("FAIL once_idle_after: got %0b expected 0", pl_w[0]); end
    endtask

    task automatic test_loop_stop();
        loop_en[0] = 1'b1;
        start[0] = 1'b1;
        run_collect(0, 70, 0);
        n_checks++; if (mon_notes.size() != 3) begin n_errors++; $display("FAIL loop_note_count: got %0d expected 3", mon_notes.size()); end
        n_checks++; if (note_at(2) !== 12'h43f || note_at(1) !== 12'h840) begin n_errors++; $display("FAIL loop_sequence: got %0h,%0h expected 840,43f", note_at(1), note_at(2)); end
        n_checks++; if (k_at(2) != 61) begin n_errors++; $display("FAIL loop_restart_time: got %0d expected 61", k_at(2)); end
        n_checks++; if (mon_dones != 0) begin n_errors++; $display("FAIL loop_no_done: got %0d expected 0", mon_dones); end
        n_checks++; if (pl_w[0] !== 1'b1) begin n_errors++; $display("FAIL loop_playing_before_stop: got %0b expected 1", pl_w[0]); end
        stop[0] = 1'b1;
        @(negedge clk);
        stop[0] = 1'b0;
        n_checks++; if (pl_w[0] !== 1'b0 || cmd_w[0] !== 12'h000) begin n_errors++; $display("FAIL stop_in_play: got playing=%0b cmd=%0h expected 0/0", pl_w[0], cmd_w[0]); end
        n_checks++; if (done_w[0] !== 1'b0) begin n_errors++; $display("FAIL stop_no_done: got %0b expected 0", done_w[0]); end
        loop_en[0] = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    task automatic test_timeout();
        int err_k;
        logic [11:0] cmd_at;
        logic        pl_at;
        seq_mode[0] = 1'b0;
        err_k = -1; cmd_at = 12'hfff; pl_at = 1'bx;
        start[0] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start[0] = 1'b0;
            if (err_k < 0 && err_w[0] === 1'b1) begin
                err_k = k; cmd_at = cmd_w[0]; pl_at = pl_w[0];
            end
        end
        n_checks++; if (err_k != 19) begin n_errors++; $display("FAIL timeout_err_time: got %0d expected 19", err_k); end
        n_checks++; if (cmd_at !== 12'h000 || pl_at !== 1'b0) begin n_errors++; $display("FAIL timeout_idle: got cmd=%0h playing=%0b expected 0/0", cmd_at, pl_at); end
        n_checks++; if (err_w[0] !== 1'b1) begin n_errors++; $display("FAIL timeout_sticky: got %0b expected 1", err_w[0]); end
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        n_checks++; if (err_w[0] !== 1'b0 || pl_w[0] !== 1'b1) begin n_errors++; $display("FAIL timeout_start_clears: got err=%0b playing=%0b expected 0/1", err_w[0], pl_w[0]); end
        stop[0] = 1'b1;
        @(negedge clk);
        stop[0] = 1'b0;
        seq_mode[0] = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit found;
        found = 1'b0;
        start[0] = 1'b1;
        for (int k = 1; k <= 60 && !found; k++) begin
            @(negedge clk);
            if (k == 1) start[0] = 1'b0;
            if (cmd_w[0] === 12'h840) found = 1'b1;
        end
        n_checks++; if (!found || pl_w[0] !== 1'b1) begin n_errors++; $display("FAIL areset_reach_issue: got found=%0b playing=%0b expected 1/1", found, pl_w[0]); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (cmd_w[0] !== 12'h000 || pl_w[0] !== 1'b0) begin n_errors++; $display("FAIL areset_immediate: got cmd=%0h playing=%0b expected 0/0", cmd_w[0], pl_w[0]); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start[0] = 1'b1; stop[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0; stop[0] = 1'b0;
        n_checks++; if (pl_w[0] !== 1'b0) begin n_errors++; $display("FAIL start_stop_same_cycle: got playing=%0b expected 0", pl_w[0]); end
        repeat (3) @(negedge clk);
        n_checks++; if (cmd_w[0] !== 12'h000 || pl_w[0] !== 1'b0) begin n_errors++; $display("FAIL start_stop_stays_idle: got cmd=%0h playing=%0b expected 0/0", cmd_w[0], pl_w[0]); end
    endtask

    task automatic test_gap_zero();
        loop_en[2] = 1'b0;
        start[2] = 1'b1;
        run_collect(2, 70, 10);
        n_checks++; if (note_at(0) !== 12'h43f || k_at(0) != 3) begin n_errors++; $display("FAIL gap0_first: got %0h@%0d expected 43f@3", note_at(0), k_at(0)); end
        n_checks++; if (note_at(1) !== 12'h840 || k_at(1) != 27) begin n_errors++; $display("FAIL gap0_next_latency: got %0h@%0d expected 840@27", note_at(1), k_at(1)); end
        n_checks++; if (mon_notes.size() != 2 || mon_dones != 1 || mon_done_k != 51) begin n_errors++; $display("FAIL gap0_end: got notes=%0d dones=%0d done_k=%0d expected 2/1/51", mon_notes.size(), mon_dones, mon_done_k); end
    endtask

    task automatic test_addr_wrap();
        loop_en[1] = 1'b0;
        start[1] = 1'b1;
        run_collect(1, 160, 0);
        n_checks++; if (mon_notes.size() != 4) begin n_errors++; $display("FAIL wrap_note_count: got %0d expected 4", mon_notes.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (note_at(i) !== (12'h820 + 12'(i))) begin
                n_errors++; $display("FAIL wrap_note%0d: got %0h expected %0h", i, note_at(i), 12'h820 + 12'(i));
            end
        end
        n_checks++; if (mon_dones != 1 || mon_done_k != 115) begin n_errors++; $display("FAIL wrap_done: got dones=%0d at %0d expected 1 at 115", mon_dones, mon_done_k); end
        n_checks++; if (addr_b !== 2'd0 || pl_w[1] !== 1'b0) begin n_errors++; $display("FAIL wrap_final: got addr=%0d playing=%0b expected 0/0", addr_b, pl_w[1]); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = '0; stop = '0; loop_en = '0;
        seq_mode = 3'b111;
        test_reset();
        test_play_once();
        test_loop_stop();
        test_timeout();
        test_async_reset();
        test_gap_zero();
        test_addr_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
